cond_branch_unit: RTL and testbench
===================================

# cond_branch_unit

Holds the architectural NZCV flag register and resolves branches for the pipelined CPU. It consumes the per-result flags produced by the ALU flag logic (zero, negative, overflow, carry). It also takes the register-zero indication used by CBZ/CBNZ, and issues a registered taken decision plus a timed pipeline flush. It sits at the EX/MEM boundary, downstream of the ALU and zero checker, and drives the fetch redirect and the younger-stage squash.

## Interface
- FLUSH_CYCLES, 2: number of cycles flush stays high after a taken branch; legal range 1–7.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- set_flags  input  1  EX instruction is flag-setting (ADDS/SUBS/ANDS); latch the ALU flags this cycle.
- alu_negative  input  1  N flag from the ALU result.
- alu_zero  input  1  Z flag from the zero checker.
- alu_carry  input  1  C flag from the adder.
- alu_overflow  input  1  V flag from the adder.
- br_valid  input  1  EX instruction is a branch.
- br_kind  input  2  00 B, 01 CBZ, 10 CBNZ, 11 B.cond.
- cond  input  4  ARM condition code for B.cond; ignored for other kinds.
- rt_zero  input  1  tested register equals zero (CBZ/CBNZ operand).
- flags_q  output  4  registered {N,Z,C,V}.
- taken  output  1  one-cycle pulse: the branch accepted last cycle is taken.
- flush  output  1  squash younger pipeline stages.

## Operation
- States: IDLE and FLUSH, with a 3-bit flush counter.
- **IDLE**
  - If set_flags=1: flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow}.
  - If br_valid=1: evaluate the branch and register the result into taken.
  - If the branch is taken: go to FLUSH and load the counter with FLUSH_CYCLES-1.
- **FLUSH**
  - set_flags and br_valid are ignored; those instructions are squashed.
  - flags_q holds. taken=0.
  - The counter decrements each cycle. At 0, return to IDLE.
- **Evaluation**
  - B: always taken.
  - CBZ: taken iff rt_zero=1.
  - CBNZ: taken iff rt_zero=0.
  - B.cond: taken iff cond holds on the selected flags (N,Z,C,V).
- **Condition codes**
  - 0 EQ Z. 1 NE !Z. 2 HS C. 3 LO !C.
  - 4 MI N. 5 PL !N. 6 VS V. 7 VC !V.
  - 8 HI C&!Z. 9 LS !C|Z. A GE N==V. B LT N!=V.
  - C GT !Z&(N==V). D LE Z|(N!=V). E AL 1. F NV, behaves as AL.
- **Flag selection:** see Configuration. CBZ/CBNZ/B never read flags.
- **Simultaneous set_flags and br_valid in IDLE:** flags_q updates and the branch is evaluated in the same cycle. Which flag set B.cond uses is set by Configuration.
- **Reset:** takes priority over all inputs.
  - Returns to IDLE, clears the counter.
  - flags_q=4'b0000, taken=0, flush=0.
  - This holds mid-FLUSH as well.

## Timing
- Decision latency is 1 cycle: br_valid sampled at edge k gives taken=1 during cycle k+1.
- flush is high for exactly FLUSH_CYCLES consecutive cycles, starting in the same cycle as taken.
- A not-taken branch produces no flush and no stall; a branch may be accepted every cycle in IDLE.
- flags_q changes the cycle after set_flags is sampled.
- The first br_valid accepted after FLUSH ends is in the cycle where flush=0 again.

## Configuration
- FLAG_FORWARD_EN
  - Defined: B.cond in the same cycle as set_flags uses the incoming alu_* flags (bypass).
  - Undefined: B.cond always uses flags_q. The compiler or hazard unit must separate a flag-setter and a dependent B.cond by at least one cycle.
  - Both builds behave identically when set_flags and br_valid are not coincident.

## Test plan
- Reset, then 3 idle cycles -> flags_q=0000, taken=0, flush=0.
- set_flags with N=0 Z=1 C=1 V=0, then B.cond cond=0 (EQ) next cycle -> taken=1 one cycle later. flush high for 2 cycles (FLUSH_CYCLES=2). br_valid B during flush ignored (taken stays 0).
- CBZ rt_zero=0, then CBNZ rt_zero=0 on back-to-back cycles -> taken=0 then taken=1. No flush for the first.
- Same-cycle set_flags with Z=1 (flags_q Z=0) and B.cond EQ:
  - FLAG_FORWARD_EN defined -> taken=1.
  - FLAG_FORWARD_EN undefined -> taken=0.
  - flags_q Z=1 afterwards in both builds.
- Flags N=1 V=0 Z=0: cond B (LT) -> taken; cond A (GE) -> not taken; cond C (GT) -> not taken; cond F -> taken.
- Taken B, then reset asserted in the first flush cycle -> next cycle flush=0, taken=0, flags_q=0000, and a new br_valid is accepted immediately.

Source files
------------

// File: rtl/cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_unit
// Brief    : NZCV flag register and branch resolver. It issues a registered
//            taken pulse and a timed flush. Optional macro: FLAG_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cond_branch_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_flags,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       br_valid,
    input  logic [1:0] br_kind,
    input  logic [3:0] cond,
    input  logic       rt_zero,
    output logic [3:0] flags_q,
    output logic       taken,
    output logic       flush
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_flush  = 1'b1;
    localparam logic [2:0] c_cnt_load  = 3'(FLUSH_CYCLES - 1);

    localparam logic [1:0] c_kind_b    = 2'b00;
    localparam logic [1:0] c_kind_cbz  = 2'b01;
    localparam logic [1:0] c_kind_cbnz = 2'b10;

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic [3:0] r_flags;
    logic       r_taken;

    logic [0:0] w_state_nxt;
    logic [2:0] w_cnt_nxt;
    logic [3:0] w_flags_nxt;
    logic       w_taken_nxt;
    logic [3:0] w_alu_flags;
    logic [3:0] w_sel_flags;
    logic       w_br_taken;

    // Flags are packed {N,Z,C,V}
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    cond_holds = z;
            4'h1:    cond_holds = !z;
            4'h2:    cond_holds = c;
            4'h3:    cond_holds = !c;
            4'h4:    cond_holds = n;
            4'h5:    cond_holds = !n;
            4'h6:    cond_holds = v;
            4'h7:    cond_holds = !v;
            4'h8:    cond_holds = c && !z;
            4'h9:    cond_holds = !c || z;
            4'hA:    cond_holds = (n == v);
            4'hB:    cond_holds = (n != v);
            4'hC:    cond_holds = !z && (n == v);
            4'hD:    cond_holds = z || (n != v);
            default: cond_holds = 1'b1;
        endcase
    endfunction

    assign w_alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

`ifdef FLAG_FORWARD_EN
    assign w_sel_flags = set_flags ? w_alu_flags : r_flags;
`else
    assign w_sel_flags = r_flags;
`endif

    always_comb begin
        w_br_taken = 1'b0;
        case (br_kind)
            c_kind_b:    w_br_taken = 1'b1;
            c_kind_cbz:  w_br_taken = rt_zero;
            c_kind_cbnz: w_br_taken = !rt_zero;
            default:     w_br_taken = cond_holds(cond, w_sel_flags);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flags_nxt = r_flags;
        w_taken_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (set_flags) begin
                    w_flags_nxt = w_alu_flags;
                end
                if (br_valid && w_br_taken) begin
                    w_taken_nxt = 1'b1;
                    w_state_nxt = c_st_flush;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            default: begin
                // Squashed instructions in the shadow of a taken branch are dropped
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 3'd0;
            r_flags <= 4'b0000;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flags <= w_flags_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    assign flags_q = r_flags;
    assign taken   = r_taken;
    assign flush   = (r_state == c_st_flush);

endmodule
`default_nettype wire

// File: tb/tb_cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_branch_unit
// Brief    : Self-checking bench for cond_branch_unit. It uses directed
//            scenarios plus random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_branch_unit;

    localparam int FLUSH_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_flags = 1'b0;
    logic       alu_negative = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_carry = 1'b0;
    logic       alu_overflow = 1'b0;
    logic       br_valid = 1'b0;
    logic [1:0] br_kind = 2'b00;
    logic [3:0] cond = 4'h0;
    logic       rt_zero = 1'b0;
    logic [3:0] flags_q;
    logic       taken;
    logic       flush;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags = 4'b0000;
    int         m_left  = 0;
    logic       m_taken = 1'b0;

    cond_branch_unit #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .set_flags    (set_flags),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .br_valid     (br_valid),
        .br_kind      (br_kind),
        .cond         (cond),
        .rt_zero      (rt_zero),
        .flags_q      (flags_q),
        .taken        (taken),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Even codes test a base predicate, odd codes its negation; 14/15 always hold
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cc[3:1] == 3'd7) ? 1'b1 : (base ^ cc[0]);
    endfunction

    task automatic model_update();
        logic [3:0] alu, sel;
        logic       t;
        alu = {alu_negative, alu_zero, alu_carry, alu_overflow};
        if (reset) begin
            m_flags = 4'b0000;
            m_left  = 0;
            m_taken = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_taken = 1'b0;
        end else begin
            sel = m_flags;
`ifdef FLAG_FORWARD_EN
            if (set_flags) sel = alu;
`endif
            case (br_kind)
                2'd0: t = 1'b1;
                2'd1: t = rt_zero;
                2'd2: t = ~rt_zero;
                default: t = ref_cond(cond, sel);
            endcase
            t = t & br_valid;
            if (set_flags) m_flags = alu;
            m_taken = t;
            if (t) m_left = FLUSH_CYCLES;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("flags_q", flags_q, m_flags);
        check_eq("taken", {3'b0, taken}, {3'b0, m_taken});
        check_eq("flush", {3'b0, flush}, {3'b0, (m_left > 0)});
    endtask

    task automatic drive(input logic rs, input logic sf, input logic [3:0] f,
                         input logic bv, input logic [1:0] k, input logic [3:0] cc,
                         input logic rz);
        reset = rs;
        set_flags = sf;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = f;
        br_valid = bv;
        br_kind = k;
        cond = cc;
        rt_zero = rz;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
    endtask

    task automatic bcond(input logic [3:0] cc);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd3, cc, 1'b0);
    endtask

    initial begin
        // Reset and idle
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
        idle(3);
        check_eq("rst_flags", flags_q, 4'b0000);
        check_eq("rst_taken", {3'b0, taken}, 4'b0000);
        check_eq("rst_flush", {3'b0, flush}, 4'b0000);

        // Flag-setter then dependent B.EQ; branch during flush is ignored
        drive(1'b0, 1'b1, 4'b0110, 1'b0, 2'd0, 4'h0, 1'b0);
        check_eq("set_flags", flags_q, 4'b0110);
        bcond(4'h0);
        check_eq("eq_taken", {3'b0, taken}, 4'b0001);
        check_eq("eq_flush1", {3'b0, flush}, 4'b0001);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0);
        check_eq("flush_b_ign", {3'b0, taken}, 4'b0000);
        check_eq("eq_flush2", {3'b0, flush}, 4'b0001);
        idle(1);
        check_eq("flush_end", {3'b0, flush}, 4'b0000);
        check_eq("no_extra_tk", {3'b0, taken}, 4'b0000);

        // CBZ not taken then CBNZ taken back to back
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 4'h0, 1'b0);
        check_eq("cbz_nt", {3'b0, taken}, 4'b0000);
        check_eq("cbz_noflush", {3'b0, flush}, 4'b0000);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h0, 1'b0);
        check_eq("cbnz_tk", {3'b0, taken}, 4'b0001);
        idle(2);

        // Same-cycle set_flags and B.EQ with stale Z=0
        drive(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0);
        drive(1'b0, 1'b1, 4'b0100, 1'b1, 2'd3, 4'h0, 1'b0);
`ifdef FLAG_FORWARD_EN
        check_eq("fwd_eq", {3'b0, taken}, 4'b0001);
`else
        check_eq("nofwd_eq", {3'b0, taken}, 4'b0000);
`endif
        check_eq("fwd_flags", flags_q, 4'b0100);
        idle(3);

        // Signed conditions with N=1 Z=0 V=0
        drive(1'b0, 1'b1, 4'b1000, 1'b0, 2'd0, 4'h0, 1'b0);
        bcond(4'hB);
        check_eq("lt_tk", {3'b0, taken}, 4'b0001);
        idle(2);
        bcond(4'hA);
        check_eq("ge_nt", {3'b0, taken}, 4'b0000);
        bcond(4'hC);
        check_eq("gt_nt", {3'b0, taken}, 4'b0000);
        bcond(4'hF);
        check_eq("nv_tk", {3'b0, taken}, 4'b0001);

        // Reset in the first flush cycle, then immediate new branch
        idle(2);
        drive(1'b0, 1'b1, 4'b1111, 1'b1, 2'd0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
        check_eq("rst_mid_fl", {3'b0, flush}, 4'b0000);
        check_eq("rst_mid_tk", {3'b0, taken}, 4'b0000);
        check_eq("rst_mid_fq", flags_q, 4'b0000);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0);
        check_eq("post_rst_tk", {3'b0, taken}, 4'b0001);
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) != 0), 2'($urandom), 4'($urandom),
                  1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
